// File: rtl/jtag_seq_master.sv
// jtag_seq_master: bit-banged JTAG initiator, 1..32 TCK pulses per command,
// TMS/TDI driven while TCK is low, TDO captured LSB first at the end of TCK high.
module jtag_seq_master #(
  parameter int TCK_LOW_CYC  = 300000,
  parameter int TCK_HIGH_CYC = 27,
  parameter int MAX_BITS     = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [5:0]          cmd_len,
  input  logic [MAX_BITS-1:0] cmd_tms,
  input  logic [MAX_BITS-1:0] cmd_tdi,
  output logic                busy,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_tdo,
  output logic                jtag_clk,
  output logic                jtag_tms,
  output logic                jtag_tdi,
  input  logic                jtag_tdo
);

  localparam int CW = 20;
  localparam int IW = $clog2(MAX_BITS);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [5:0]          len_r;
  logic [5:0]          len_clamp;
  logic                last_bit;
  logic [MAX_BITS-1:0] tms_r;
  logic [MAX_BITS-1:0] tdi_r;
  logic                tdo_meta;
  logic                tdo_sync;

  always_comb begin
    len_clamp = cmd_len;
    if (cmd_len > 6'(MAX_BITS)) len_clamp = 6'(MAX_BITS);
    idx_nxt  = idx + 1'b1;
    last_bit = (6'(idx) + 6'd1) == len_r;
  end

  // TDO is asynchronous to sys_clk
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tdo_meta <= 1'b0;
      tdo_sync <= 1'b0;
    end else begin
      tdo_meta <= jtag_tdo;
      tdo_sync <= tdo_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      len_r     <= '0;
      tms_r     <= '0;
      tdi_r     <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tdo   <= '0;
      jtag_clk  <= 1'b0;
      jtag_tms  <= 1'b1;
      jtag_tdi  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            len_r     <= len_clamp;
            tms_r     <= cmd_tms;
            tdi_r     <= cmd_tdi;
            rsp_tdo   <= '0;
            idx       <= '0;
            if (len_clamp == 6'd0) begin
              state <= DONE;
            end else begin
              state    <= LOW;
              jtag_tms <= cmd_tms[0];
              jtag_tdi <= cmd_tdi[0];
              cnt      <= CW'(TCK_LOW_CYC - 1);
            end
          end
        end
        LOW: begin
          if (cnt == '0) begin
            state    <= HIGH;
            jtag_clk <= 1'b1;
            cnt      <= CW'(TCK_HIGH_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            rsp_tdo[idx] <= tdo_sync;
            jtag_clk     <= 1'b0;
            if (last_bit) begin
              state <= DONE;
            end else begin
              state    <= LOW;
              idx      <= idx_nxt;
              jtag_tms <= tms_r[idx_nxt];
              jtag_tdi <= tdi_r[idx_nxt];
              cnt      <= CW'(TCK_LOW_CYC - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_seq_master.sv
// tb_jtag_seq_master: directed checks of jtag_seq_master with short TCK phases
// (4 low / 3 high) and a TDO shifter that advances on TCK falling edges.
module tb_jtag_seq_master;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_tdo;
  logic        jtag_clk;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_tdo;

  int n_tests;
  int n_fail;

  jtag_seq_master #(
    .TCK_LOW_CYC (4),
    .TCK_HIGH_CYC(3),
    .MAX_BITS    (32)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .cmd_tms  (cmd_tms),
    .cmd_tdi  (cmd_tdi),
    .busy     (busy),
    .rsp_valid(rsp_valid),
    .rsp_tdo  (rsp_tdo),
    .jtag_clk (jtag_clk),
    .jtag_tms (jtag_tms),
    .jtag_tdi (jtag_tdi),
    .jtag_tdo (jtag_tdo)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int          rises;
  int          falls;
  int          hi_cyc;
  int          rise_base;
  int          fall_base;
  int          hi_base;
  logic [31:0] tms_sh;
  logic [31:0] tdi_sh;
  logic [31:0] tdo_pat;
  logic [4:0]  tdo_i;

  initial begin
    rises  = 0;
    falls  = 0;
    hi_cyc = 0;
    tms_sh = '0;
    tdi_sh = '0;
  end

  always @(posedge jtag_clk) begin
    rises  = rises + 1;
    tms_sh = {jtag_tms, tms_sh[31:1]};
    tdi_sh = {jtag_tdi, tdi_sh[31:1]};
  end

  always @(negedge jtag_clk) falls = falls + 1;

  always @(negedge sys_clk) if (jtag_clk) hi_cyc = hi_cyc + 1;

  // target shifts its next TDO bit out on each TCK falling edge
  assign tdo_i    = 5'(falls - fall_base);
  assign jtag_tdo = tdo_pat[tdo_i];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input logic [5:0] len, input logic [31:0] tms,
                           input logic [31:0] tdi);
    bit ok;
    @(negedge sys_clk);
    cmd_len   = len;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    check("accept_wait", 32'(ok), 32'd1);
    rise_base = rises;
    fall_base = falls;
    hi_base   = hi_cyc;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int j = 0; j < 400; j++) begin
      @(negedge sys_clk);
      if (rsp_valid) begin
        lat = j;
        break;
      end
    end
  endtask

  int lat;
  int seen_rsp;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_tms   = '0;
    cmd_tdi   = '0;
    tdo_pat   = '0;
    fall_base = 0;
    rise_base = 0;
    hi_base   = 0;

    // 1 reset values and cmd_ready after release
    repeat (3) @(negedge sys_clk);
    check("rst_clk", 32'(jtag_clk), 32'd0);
    check("rst_tms", 32'(jtag_tms), 32'd1);
    check("rst_tdi", 32'(jtag_tdi), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tdo", rsp_tdo, 32'd0);
    sys_rst_n = 1'b1;
    #1;
    check("rel_ready0", 32'(cmd_ready), 32'd0);
    @(negedge sys_clk);
    check("rel_ready1", 32'(cmd_ready), 32'd1);

    // 2 len=5, tms all ones
    start_cmd(6'd5, 32'h1F, 32'h0);
    cmd_valid = 1'b0;
    check("t2_busy", 32'(busy), 32'd1);
    wait_rsp(lat);
    check("t2_lat", 32'(lat), 32'd36);
    check("t2_busy_rsp", 32'(busy), 32'd1);
    check("t2_pulses", 32'(rises - rise_base), 32'd5);
    check("t2_hi_cyc", 32'(hi_cyc - hi_base), 32'd15);
    check("t2_tms", 32'(tms_sh[31:27]), 32'h1F);
    @(negedge sys_clk);
    check("t2_ready", 32'(cmd_ready), 32'd1);
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_rsp_pulse", 32'(rsp_valid), 32'd0);

    // 3 len=8 with TDO pattern
    tdo_pat = 32'h3C;
    start_cmd(6'd8, 32'h0, 32'hA5);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("t3_lat", 32'(lat), 32'd57);
    check("t3_pulses", 32'(rises - rise_base), 32'd8);
    check("t3_tdi", 32'(tdi_sh[31:24]), 32'hA5);
    check("t3_tdo", rsp_tdo, 32'h3C);
    check("t3_clk_idle", 32'(jtag_clk), 32'd0);

    // 4 len=0 and clamped len=40
    start_cmd(6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("t4a_lat", 32'(lat), 32'd1);
    check("t4a_pulses", 32'(rises - rise_base), 32'd0);
    check("t4a_tdo", rsp_tdo, 32'd0);
    tdo_pat = 32'hDEAD_BEEF;
    start_cmd(6'd40, 32'h0, 32'h1234_5678);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("t4b_lat", 32'(lat), 32'd225);
    check("t4b_pulses", 32'(rises - rise_base), 32'd32);
    check("t4b_tdi", tdi_sh, 32'h1234_5678);
    check("t4b_tdo", rsp_tdo, 32'hDEAD_BEEF);

    // 5 cmd_* changed while busy with cmd_valid held
    tdo_pat = 32'h0;
    start_cmd(6'd4, 32'h5, 32'hF);
    cmd_len = 6'd2;
    cmd_tms = 32'hA;
    cmd_tdi = 32'h0;
    wait_rsp(lat);
    check("t5_lat", 32'(lat), 32'd29);
    check("t5_pulses", 32'(rises - rise_base), 32'd4);
    check("t5_tms", 32'(tms_sh[31:28]), 32'h5);
    check("t5_tdi", 32'(tdi_sh[31:28]), 32'hF);
    @(negedge sys_clk);
    check("t5_ready", 32'(cmd_ready), 32'd1);
    rise_base = rises;
    @(negedge sys_clk);
    check("t5_acc_busy", 32'(busy), 32'd1);
    check("t5_acc_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("t5_lat2", 32'(lat), 32'd14);
    check("t5_pulses2", 32'(rises - rise_base), 32'd2);
    check("t5_tms2", 32'(tms_sh[31:30]), 32'h2);

    // 6 reset during HIGH of bit 2
    start_cmd(6'd6, 32'h0, 32'h3F);
    cmd_valid = 1'b0;
    repeat (19) @(negedge sys_clk);
    check("t6_in_high", 32'(jtag_clk), 32'd1);
    check("t6_tms_pre", 32'(jtag_tms), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    check("t6_clk", 32'(jtag_clk), 32'd0);
    check("t6_tms", 32'(jtag_tms), 32'd1);
    check("t6_tdi", 32'(jtag_tdi), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(cmd_ready), 32'd0);
    seen_rsp = 0;
    repeat (3) begin
      @(negedge sys_clk);
      if (rsp_valid) seen_rsp++;
    end
    sys_rst_n = 1'b1;
    repeat (60) begin
      @(negedge sys_clk);
      if (rsp_valid) seen_rsp++;
    end
    check("t6_no_rsp", 32'(seen_rsp), 32'd0);
    check("t6_ready_after", 32'(cmd_ready), 32'd1);
    start_cmd(6'd2, 32'h3, 32'h1);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("t6_lat", 32'(lat), 32'd15);
    check("t6_pulses", 32'(rises - rise_base), 32'd2);
    check("t6_tdi2", 32'(tdi_sh[31:30]), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
